// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// uart_tx_buffered : byte FIFO feeding a baud-timed 8N1 serializer
// Revision 1.0
// ============================================================================
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             overflow,
  output logic             uart_tx
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam logic [BCW-1:0]   C_BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  state_t           state_q;
  logic [BCW-1:0]   baud_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;

  logic             w_bit_done;
  logic             w_push;
  logic             w_pop;

  assign full       = (count_q == C_DEPTH);
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign busy       = (state_q != S_IDLE);
  assign overflow   = overflow_q;
  assign uart_tx    = tx_q;

  assign w_bit_done = (baud_q == C_BAUD_LAST);
  // full is sampled before the edge, so a pop on the same edge never rescues a write
  assign w_push     = wr_en & ~full;
  assign w_pop      = ~empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & w_bit_done));

  always_comb begin
    wptr_d     = w_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = w_pop  ? rptr_q + 1'b1 : rptr_q;
    overflow_d = overflow_q | (wr_en & full);
    count_d    = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (w_pop) begin
            shift_q <= mem_q[rptr_q];
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (w_bit_done) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            baud_q <= '0;
            // chain straight into the next start bit when more data is queued
            if (w_pop) begin
              shift_q <= mem_q[rptr_q];
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          baud_q  <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// Bench for uart_tx_buffered: directed scenarios plus random traffic, checked
// against a frame-timing queue model and a line decoder.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full, empty, busy, overflow, uart_tx;
  logic [CW-1:0] count;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .busy    (busy),
    .overflow(overflow),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: queued bytes, cycles left in the current frame
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  int         m_rem = 0;
  logic [7:0] m_cur = 8'h00;
  logic       m_ovf = 1'b0;

  // line decoder
  bit         dec_act = 1'b0;
  int         dec_pos = 0;
  logic [7:0] dec_byte = 8'h00;
  logic [7:0] rx[$];
  logic [7:0] exp_rx[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_line();
    int pos, b;
    if (m_rem == 0) return 1'b1;
    pos = FRAME - m_rem;
    b   = pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  task automatic step(input logic we, input logic [7:0] d);
    int  pre_size;
    bit  do_pop;
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    if (!rst) begin
      m_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      pre_size = m_q.size();
      do_pop   = (pre_size > 0) && (m_rem <= 1);
      if (we && pre_size == DEPTH) m_ovf = 1'b1;
      if (do_pop) begin
        m_cur = m_q.pop_front();
        m_sent.push_back(m_cur);
        m_rem = FRAME;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (we && pre_size < DEPTH) m_q.push_back(d);
    end
    @(negedge clk);
    check_eq("count",    32'(count),    32'(m_q.size()));
    check_eq("full",     32'(full),     32'(m_q.size() == DEPTH));
    check_eq("empty",    32'(empty),    32'(m_q.size() == 0));
    check_eq("busy",     32'(busy),     32'(m_rem > 0));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("uart_tx",  32'(uart_tx),  32'(exp_line()));
    if (!rst) begin
      dec_act = 1'b0;
    end else if (dec_act) begin
      dec_pos++;
      if (dec_pos >= 6 && dec_pos <= 34 && (dec_pos % CPB) == 2)
        dec_byte[(dec_pos - 6) / CPB] = uart_tx;
      if (dec_pos == 38) begin
        check_eq("stop_bit", 32'(uart_tx), 32'd1);
        rx.push_back(dec_byte);
      end
      if (dec_pos == 39) dec_act = 1'b0;
    end else if (uart_tx == 1'b0) begin
      dec_act = 1'b1;
      dec_pos = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 1500 && (m_rem != 0 || m_q.size() != 0); i++) step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check_eq("drain_busy",  32'(busy),  32'd0);
    check_eq("drain_empty", 32'(empty), 32'd1);
  endtask

  task automatic cmp_rx(input string tag);
    check_eq({tag, "_n"}, 32'(rx.size()), 32'(exp_rx.size()));
    for (int i = 0; i < rx.size() && i < exp_rx.size(); i++)
      check_eq({tag, "_byte"}, 32'(rx[i]), 32'(exp_rx[i]));
    rx.delete();
    exp_rx.delete();
    m_sent.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    rx.delete();
    m_sent.delete();
  endtask

  initial begin
    do_reset();
    check_eq("rst_tx",    32'(uart_tx),  32'd1);
    check_eq("rst_count", 32'(count),    32'd0);
    check_eq("rst_busy",  32'(busy),     32'd0);
    check_eq("rst_empty", 32'(empty),    32'd1);
    check_eq("rst_ovf",   32'(overflow), 32'd0);

    // single byte: start bit appears on the second edge after the write
    step(1'b1, 8'h55);
    check_eq("lat_tx_high", 32'(uart_tx), 32'd1);
    check_eq("lat_count",   32'(count),   32'd1);
    step(1'b0, 8'h00);
    check_eq("lat_tx_low",  32'(uart_tx), 32'd0);
    drain();
    exp_rx = '{8'h55};
    cmp_rx("single");

    // back-to-back frames
    step(1'b1, 8'hA3);
    step(1'b1, 8'h0F);
    drain();
    exp_rx = '{8'hA3, 8'h0F};
    cmp_rx("b2b");

    // overflow on the sixth consecutive write
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
    check_eq("ovf_full", 32'(full),     32'd1);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    drain();
    check_eq("ovf_sticky", 32'(overflow), 32'd1);
    exp_rx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    cmp_rx("ovf");

    // pointer wrap: 12 bytes, each only offered while not full
    do_reset();
    begin
      int idx = 0;
      for (int cyc = 0; cyc < 800 && idx < 12; cyc++) begin
        if (!full) begin
          step(1'b1, 8'(8'h10 + idx));
          idx++;
        end else begin
          step(1'b0, 8'h00);
        end
        check_eq("wrap_cnt_max", 32'(count <= CW'(DEPTH)), 32'd1);
      end
      check_eq("wrap_all_written", 32'(idx), 32'd12);
    end
    drain();
    for (int i = 0; i < 12; i++) exp_rx.push_back(8'(8'h10 + i));
    cmp_rx("wrap");

    // push on the same edge that ends a stop bit and pops the next byte
    step(1'b1, 8'h31);
    step(1'b1, 8'h32);
    step(1'b1, 8'h33);
    for (int i = 0; i < 60 && m_rem != 1; i++) step(1'b0, 8'h00);
    check_eq("coll_pre",  32'(count), 32'd2);
    step(1'b1, 8'h77);
    check_eq("coll_post", 32'(count), 32'd2);
    drain();
    exp_rx = '{8'h31, 8'h32, 8'h33, 8'h77};
    cmp_rx("coll");

    // asynchronous reset in the middle of the data bits
    step(1'b1, 8'hC6);
    idle(20);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_tx",    32'(uart_tx), 32'd1);
    check_eq("arst_count", 32'(count),   32'd0);
    check_eq("arst_busy",  32'(busy),    32'd0);
    idle(2);
    rst = 1'b1;
    rx.delete();
    m_sent.delete();
    step(1'b1, 8'hC6);
    drain();
    exp_rx = '{8'hC6};
    cmp_rx("arst");

    // random traffic, including bursts that overrun the FIFO
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) step(1'b1, 8'($urandom));
      else                           step(1'b0, 8'h00);
    end
    drain();
    exp_rx = m_sent;
    cmp_rx("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
